eth_latency_tracker: RTL and testbench
======================================

ETH_LATENCY_TRACKER -- requirements
Module: eth_latency_tracker

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of independent ping channels (1..8); CW = max(1, ceil(log2(NUM_CHANNELS))).
REQ-002 SHALL have parameter SEQ_WIDTH, default 16, ping sequence-number width (8..32).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, result FIFO entries (power of two, 2..64).
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 current_time  in  64  free-running timestamp.
REQ-007 time_running  in  1  timer enable.
REQ-008 clear  in  1  synchronous clear pulse.
REQ-009 timeout  in  32  loss threshold in time units; 0 disables timeouts.
REQ-010 tx_valid / tx_channel / tx_seq  in  1 / CW / SEQ_WIDTH  ping-sent event.
REQ-011 rx_valid / rx_channel / rx_seq  in  1 / CW / SEQ_WIDTH  pong-received event.
REQ-012 res_valid  out  1  result FIFO non-empty.
REQ-013 res_ready  in  1  result consumer ready.
REQ-014 res_channel / res_lost / res_latency  out  CW / 1 / 64  head result: channel, timeout flag, latency (0 when lost).
REQ-015 res_drops  out  16  results dropped on full FIFO, saturating.
REQ-016 stat_sel  in  CW  statistics channel select.
REQ-017 stat_ok / stat_lost  out  32 / 32  selected channel answered / lost counts, wrapping.
REQ-018 stat_min / stat_max  out  64 / 64  selected channel latency extremes.

Function
REQ-019 Each channel SHALL hold state IDLE or WAIT plus stored timestamp and sequence.
REQ-020 tx_valid with time_running=1: channel -> WAIT, stores current_time and tx_seq; tx_valid with time_running=0 ignored.
REQ-021 tx_valid on a channel already in WAIT (overrun): stat_lost of that channel +1, no result record, new ping replaces old.
REQ-022 rx_valid on a channel in WAIT with rx_seq == stored seq: latency = current_time - stored time (unsigned, modulo 2^64), channel -> IDLE, result {channel, lost=0, latency} enqueued, stat_ok +1, min/max updated.
REQ-023 rx_valid on IDLE channel or with sequence mismatch SHALL be ignored entirely.
REQ-024 rx and tx on same channel in same cycle: rx evaluated against old state first, then tx loads new state.
REQ-025 Timeout scanner SHALL examine one channel per cycle, round-robin 0..NUM_CHANNELS-1; if WAIT and (current_time - stored time) > timeout and timeout != 0: channel -> IDLE, result {channel, lost=1, latency=0} enqueued, stat_lost +1.
REQ-026 At most one enqueue per cycle; rx match has priority; scanner holds its pointer (no advance) when rx enqueues, when FIFO full, or when time_running=0.
REQ-027 rx-match result with FIFO full SHALL be dropped (res_drops +1), channel/stat updates still applied.
REQ-028 Dequeue on res_valid & res_ready; simultaneous enqueue and dequeue on full FIFO SHALL accept the enqueue.
REQ-029 Outputs res_* SHALL be driven from FIFO head, zero latency after enqueue cycle +1.
REQ-030 stat_* SHALL be registered, valid one cycle after stat_sel changes.
REQ-031 clear SHALL set all channels IDLE, flush FIFO, reset stats and res_drops; events in the clear cycle ignored.

Reset
REQ-032 rst SHALL force: all channels IDLE, FIFO empty, res_valid=0, res_channel=0, res_lost=0, res_latency=0, res_drops=0, scanner pointer 0, stat_ok=stat_lost=0, stat_min=all-ones, stat_max=0; mid-operation reset discards outstanding pings.

Configuration
REQ-033 Macro ETH_LATENCY_TRACKER_STATS_EN defined: per-channel stat_ok/stat_lost/stat_min/stat_max logic present per REQ-017/018/022/025.
REQ-034 Macro undefined: stats logic removed, stat_* outputs constant 0, all other behaviour unchanged.

Verification
REQ-035 tx ch1 seq 5 at t=100, rx ch1 seq 5 at t=350 -> one result ch1 lost=0 latency=250; stat_ok(1)=1, min=max=250.
REQ-036 timeout=1000, tx ch2 at t=0, no rx -> result ch2 lost=1 within NUM_CHANNELS cycles after t>1000; stat_lost(2)=1.
REQ-037 tx ch0 seq 7, rx ch0 seq 8 -> no result, channel stays WAIT; later rx seq 7 -> result.
REQ-038 res_ready=0, FIFO_DEPTH+2 matched pings -> FIFO_DEPTH results held, res_drops=2.
REQ-039 tx ch3 at t=0xFFFF_FFFF_FFFF_FFF0, rx at t=0x10 -> latency=0x20.
REQ-040 tx twice on ch0 then rx second seq -> stat_lost(0)=1, stat_ok(0)=1; clear pulse -> all stats 0, res_valid=0.

Source files
------------

// File: rtl/eth_latency_tracker.sv
// eth_latency_tracker
//   Measures ping/pong round-trip latency on NUM_CHANNELS independent
//   channels. A tx event arms a channel with a timestamp and sequence
//   number. A matching rx event produces a latency result. A round-robin
//   scanner retires pings older than `timeout` as lost. Results are queued
//   in a FIFO_DEPTH-entry FIFO. Results that arrive while the FIFO is full
//   are dropped and counted.
//
// Optional feature: define ETH_LATENCY_TRACKER_STATS_EN to build the
//   per-channel statistics (ok/lost counts, min/max latency). When it is
//   undefined, stat_* are tied to 0.
//
// Ports
//   clk, rst                     clock, async active-high reset
//   current_time, time_running   timestamp source and timer enable
//   clear                        synchronous flush of all state
//   timeout                      loss threshold (0 = never time out)
//   tx_valid/tx_channel/tx_seq   ping sent
//   rx_valid/rx_channel/rx_seq   pong received
//   res_valid/res_ready          result FIFO handshake
//   res_channel/res_lost/res_latency  FIFO head
//   res_drops                    saturating count of dropped results
//   stat_sel                     channel for stat_* (registered outputs)
//   stat_ok/stat_lost/stat_min/stat_max  statistics of selected channel
module eth_latency_tracker #(
  parameter  int NUM_CHANNELS = 4,
  parameter  int SEQ_WIDTH    = 16,
  parameter  int FIFO_DEPTH   = 8,
  localparam int CW           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int AW           = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          current_time,
  input  logic                 time_running,
  input  logic                 clear,
  input  logic [31:0]          timeout,
  input  logic                 tx_valid,
  input  logic [CW-1:0]        tx_channel,
  input  logic [SEQ_WIDTH-1:0] tx_seq,
  input  logic                 rx_valid,
  input  logic [CW-1:0]        rx_channel,
  input  logic [SEQ_WIDTH-1:0] rx_seq,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CW-1:0]        res_channel,
  output logic                 res_lost,
  output logic [63:0]          res_latency,
  output logic [15:0]          res_drops,
  input  logic [CW-1:0]        stat_sel,
  output logic [31:0]          stat_ok,
  output logic [31:0]          stat_lost,
  output logic [63:0]          stat_min,
  output logic [63:0]          stat_max
);

  typedef struct packed {
    logic [CW-1:0] ch;
    logic          lost;
    logic [63:0]   lat;
  } res_t;

  // Channel state
  logic [NUM_CHANNELS-1:0] wait_q, wait_d;
  logic [63:0]             ts_q  [NUM_CHANNELS];
  logic [SEQ_WIDTH-1:0]    seq_q [NUM_CHANNELS];

  // Result FIFO
  res_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic [15:0]   drops_q;

  // Scanner
  logic [CW-1:0] scan_q, scan_d;

  logic        tx_inr, rx_inr;
  logic        tx_in, rx_match, overrun;
  logic [63:0] rx_lat, scan_age;
  logic        full, deq, can_enq;
  logic        scan_exp, scan_hold, scan_fire;
  logic        enq_req, enq, drop;
  res_t        enq_data, head;

  // Channel numbers beyond NUM_CHANNELS are only possible when the channel
  // count is not a power of two.
  if (NUM_CHANNELS == (1 << CW)) begin : g_full_range
    assign tx_inr = 1'b1;
    assign rx_inr = 1'b1;
  end else begin : g_part_range
    assign tx_inr = ({1'b0, tx_channel} < (CW+1)'(NUM_CHANNELS));
    assign rx_inr = ({1'b0, rx_channel} < (CW+1)'(NUM_CHANNELS));
  end

  assign tx_in    = tx_valid && time_running && tx_inr;
  assign rx_match = rx_valid && rx_inr && wait_q[rx_channel] &&
                    (seq_q[rx_channel] == rx_seq);
  assign rx_lat   = current_time - ts_q[rx_channel];

  assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign deq      = res_valid && res_ready;
  // A dequeue in the same cycle frees the slot an enqueue needs.
  assign can_enq  = !full || deq;

  assign scan_age  = current_time - ts_q[scan_q];
  assign scan_exp  = wait_q[scan_q] && (timeout != 32'd0) &&
                     (scan_age > {32'd0, timeout});
  assign scan_hold = rx_match || !can_enq || !time_running;
  assign scan_fire = !scan_hold && scan_exp;
  assign scan_d    = scan_hold ? scan_q :
                     (scan_q == CW'(NUM_CHANNELS-1)) ? '0 : scan_q + CW'(1);

  assign enq_req  = rx_match || scan_fire;
  assign enq      = enq_req && can_enq;
  assign drop     = rx_match && !can_enq;
  assign enq_data = rx_match ? '{ch: rx_channel, lost: 1'b0, lat: rx_lat}
                             : '{ch: scan_q,     lost: 1'b1, lat: 64'd0};

  // rx and the scanner act on the old state first; tx then re-arms. An
  // overrun is a tx that finds the channel still waiting after that.
  always_comb begin
    wait_d = wait_q;
    if (rx_match)  wait_d[rx_channel] = 1'b0;
    if (scan_fire) wait_d[scan_q]     = 1'b0;
    overrun = tx_in && wait_d[tx_channel];
    if (tx_in)     wait_d[tx_channel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      scan_q  <= '0;
      drops_q <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        ts_q[i]  <= '0;
        seq_q[i] <= '0;
      end
    end else if (clear) begin
      wait_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      scan_q  <= '0;
      drops_q <= '0;
    end else begin
      wait_q <= wait_d;
      scan_q <= scan_d;
      if (tx_in) begin
        ts_q[tx_channel]  <= current_time;
        seq_q[tx_channel] <= tx_seq;
      end
      if (enq) wr_q <= wr_q + AW'(1);
      if (deq) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(enq) - (AW+1)'(deq);
      if (drop && (drops_q != 16'hFFFF)) drops_q <= drops_q + 16'd1;
    end
  end

  // Storage only; occupancy is tracked by cnt_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq && !clear) mem_q[wr_q] <= enq_data;
  end

  assign head        = mem_q[rd_q];
  assign res_valid   = (cnt_q != '0);
  assign res_channel = res_valid ? head.ch   : '0;
  assign res_lost    = res_valid ? head.lost : 1'b0;
  assign res_latency = res_valid ? head.lat  : 64'd0;
  assign res_drops   = drops_q;

`ifdef ETH_LATENCY_TRACKER_STATS_EN
  logic [31:0] ok_q   [NUM_CHANNELS];
  logic [31:0] lost_q [NUM_CHANNELS];
  logic [63:0] min_q  [NUM_CHANNELS];
  logic [63:0] max_q  [NUM_CHANNELS];
  logic [31:0] stat_ok_q, stat_lost_q;
  logic [63:0] stat_min_q, stat_max_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        ok_q[i]   <= '0;
        lost_q[i] <= '0;
        min_q[i]  <= '1;
        max_q[i]  <= '0;
      end
      stat_ok_q   <= '0;
      stat_lost_q <= '0;
      stat_min_q  <= '1;
      stat_max_q  <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        ok_q[i]   <= '0;
        lost_q[i] <= '0;
        min_q[i]  <= '1;
        max_q[i]  <= '0;
      end
      stat_ok_q   <= '0;
      stat_lost_q <= '0;
      stat_min_q  <= '1;
      stat_max_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (rx_match && (rx_channel == CW'(i))) begin
          ok_q[i] <= ok_q[i] + 32'd1;
          if (rx_lat < min_q[i]) min_q[i] <= rx_lat;
          if (rx_lat > max_q[i]) max_q[i] <= rx_lat;
        end
        // Timeout and overrun can hit different channels in one cycle.
        lost_q[i] <= lost_q[i]
                   + 32'(scan_fire && (scan_q == CW'(i)))
                   + 32'(overrun && (tx_channel == CW'(i)));
      end
      stat_ok_q   <= ok_q[stat_sel];
      stat_lost_q <= lost_q[stat_sel];
      stat_min_q  <= min_q[stat_sel];
      stat_max_q  <= max_q[stat_sel];
    end
  end

  assign stat_ok   = stat_ok_q;
  assign stat_lost = stat_lost_q;
  assign stat_min  = stat_min_q;
  assign stat_max  = stat_max_q;
`else
  wire unused_stat = ^{stat_sel, overrun};
  assign stat_ok   = '0;
  assign stat_lost = '0;
  assign stat_min  = '0;
  assign stat_max  = '0;
`endif

endmodule

// File: tb/tb_eth_latency_tracker.sv
module tb_eth_latency_tracker;
  localparam int N  = 4;
  localparam int SW = 16;
  localparam int D  = 8;
  localparam int CW = 2;
`ifdef ETH_LATENCY_TRACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0, rst = 1'b1;
  logic [63:0]   current_time = '0;
  logic          time_running = 1'b1, clear = 1'b0;
  logic [31:0]   timeout = '0;
  logic          tx_valid = 1'b0, rx_valid = 1'b0, res_ready = 1'b0;
  logic [CW-1:0] tx_channel = '0, rx_channel = '0, stat_sel = '0;
  logic [SW-1:0] tx_seq = '0, rx_seq = '0;
  logic          res_valid, res_lost;
  logic [CW-1:0] res_channel;
  logic [63:0]   res_latency, stat_min, stat_max;
  logic [15:0]   res_drops;
  logic [31:0]   stat_ok, stat_lost;

  eth_latency_tracker #(.NUM_CHANNELS(N), .SEQ_WIDTH(SW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .current_time(current_time),
    .time_running(time_running), .clear(clear), .timeout(timeout),
    .tx_valid(tx_valid), .tx_channel(tx_channel), .tx_seq(tx_seq),
    .rx_valid(rx_valid), .rx_channel(rx_channel), .rx_seq(rx_seq),
    .res_valid(res_valid), .res_ready(res_ready), .res_channel(res_channel),
    .res_lost(res_lost), .res_latency(res_latency), .res_drops(res_drops),
    .stat_sel(stat_sel), .stat_ok(stat_ok), .stat_lost(stat_lost),
    .stat_min(stat_min), .stat_max(stat_max));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  bit use_model = 1'b1;

  // Reference model: channel table, expected result queue, statistics.
  typedef struct { int ch; bit lost; logic [63:0] lat; } r_t;
  r_t          m_q[$];
  bit          m_wait [N];
  logic [63:0] m_ts   [N];
  int          m_seq  [N];
  int unsigned m_ok   [N];
  int unsigned m_lost [N];
  logic [63:0] m_min  [N];
  logic [63:0] m_max  [N];
  int          m_drops;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_drops = 0;
    for (int i = 0; i < N; i++) begin
      m_wait[i] = 0; m_ts[i] = '0; m_seq[i] = 0;
      m_ok[i] = 0; m_lost[i] = 0; m_min[i] = ONES; m_max[i] = '0;
    end
  endtask

  // Valid only while timeouts are disabled: every result then comes from rx.
  task automatic model_step(input bit txv, input int txc, input int txs,
                            input bit rxv, input int rxc, input int rxs,
                            input bit rdy, input logic [63:0] t, input bit tr,
                            input bit clr);
    bit deq, match;
    logic [63:0] lat;
    r_t r;
    deq = (m_q.size() != 0) && rdy;
    if (clr) model_reset();
    else begin
      match = rxv && m_wait[rxc] && (m_seq[rxc] == rxs);
      lat = t - m_ts[rxc];
      if (match) begin
        m_wait[rxc] = 0;
        m_ok[rxc]++;
        if (lat < m_min[rxc]) m_min[rxc] = lat;
        if (lat > m_max[rxc]) m_max[rxc] = lat;
      end
      if (txv && tr) begin
        if (m_wait[txc]) m_lost[txc]++;
        m_wait[txc] = 1; m_ts[txc] = t; m_seq[txc] = txs;
      end
      if (deq) void'(m_q.pop_front());
      if (match) begin
        if (m_q.size() < D) begin
          r.ch = rxc; r.lost = 0; r.lat = lat;
          m_q.push_back(r);
        end else if (m_drops < 65535) m_drops++;
      end
    end
  endtask

  task automatic do_cycle(input bit txv, input int txc, input int txs,
                          input bit rxv, input int rxc, input int rxs,
                          input bit rdy, input logic [63:0] t,
                          input bit tr = 1'b1, input bit clr = 1'b0);
    tx_valid = txv; tx_channel = CW'(txc); tx_seq = SW'(txs);
    rx_valid = rxv; rx_channel = CW'(rxc); rx_seq = SW'(rxs);
    res_ready = rdy; current_time = t; time_running = tr; clear = clr;
    if (use_model) model_step(txv, txc, txs & 16'hFFFF, rxv, rxc, rxs & 16'hFFFF, rdy, t, tr, clr);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 0; rx_valid = 0; clear = 0;
    if (use_model) begin
      chk("res_valid", 64'(res_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("res_channel", 64'(res_channel), 64'(m_q[0].ch));
        chk("res_lost", 64'(res_lost), 64'(m_q[0].lost));
        chk("res_latency", res_latency, m_q[0].lat);
      end
      chk("res_drops", 64'(res_drops), 64'(m_drops));
    end
  endtask

  task automatic idle(input logic [63:0] t);
    do_cycle(0, 0, 0, 0, 0, 0, 0, t);
  endtask

  task automatic stat_chk(input string tag, input int ch, input int unsigned ok,
                          input int unsigned lost, input logic [63:0] mn,
                          input logic [63:0] mx);
    stat_sel = CW'(ch);
    idle(current_time);
    idle(current_time);
    chk({tag, "_ok"},   64'(stat_ok),   STATS ? 64'(ok)   : 64'd0);
    chk({tag, "_lost"}, 64'(stat_lost), STATS ? 64'(lost) : 64'd0);
    chk({tag, "_min"},  stat_min,       STATS ? mn        : 64'd0);
    chk({tag, "_max"},  stat_max,       STATS ? mx        : 64'd0);
  endtask

  task automatic do_clear();
    do_cycle(0, 0, 0, 0, 0, 0, 0, current_time, 1, 1);
  endtask

  initial begin
    int cnt;
    logic [63:0] now;
    int txc, rxc, rxs;
    model_reset();
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(res_valid), 0);
    chk("rst_channel", 64'(res_channel), 0);
    chk("rst_lost", 64'(res_lost), 0);
    chk("rst_latency", res_latency, 0);
    chk("rst_drops", 64'(res_drops), 0);
    chk("rst_ok", 64'(stat_ok), 0);
    chk("rst_slost", 64'(stat_lost), 0);
    chk("rst_min", stat_min, STATS ? ONES : 64'd0);
    chk("rst_max", stat_max, 0);
    rst = 0;
    idle(0);

    // Basic latency: tx ch1 at 100, rx at 350
    do_cycle(1, 1, 5, 0, 0, 0, 0, 100);
    do_cycle(0, 0, 0, 1, 1, 5, 0, 350);
    chk("b_valid", 64'(res_valid), 1);
    chk("b_ch", 64'(res_channel), 1);
    chk("b_lost", 64'(res_lost), 0);
    chk("b_lat", res_latency, 250);
    stat_chk("b_st1", 1, 1, 0, 250, 250);
    do_cycle(0, 0, 0, 0, 0, 0, 1, 400);
    chk("b_empty", 64'(res_valid), 0);

    // Sequence mismatch is ignored, later match completes
    do_cycle(1, 0, 7, 0, 0, 0, 0, 500);
    do_cycle(0, 0, 0, 1, 0, 8, 0, 510);
    chk("sq_nores", 64'(res_valid), 0);
    do_cycle(0, 0, 0, 1, 0, 7, 0, 530);
    chk("sq_lat", res_latency, 30);
    do_cycle(0, 0, 0, 0, 0, 0, 1, 540);

    // tx with timer stopped is ignored
    do_cycle(1, 2, 3, 0, 0, 0, 0, 600, 0);
    do_cycle(0, 0, 0, 1, 2, 3, 0, 610);
    chk("tr0_nores", 64'(res_valid), 0);

    // Wrap-around latency
    do_cycle(1, 3, 9, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF0);
    do_cycle(0, 0, 0, 1, 3, 9, 0, 64'h10);
    chk("wrap_lat", res_latency, 64'h20);
    do_cycle(0, 0, 0, 0, 0, 0, 1, 64'h20);
    do_clear();

    // FIFO overflow: D+2 matched pings with consumer stalled
    for (int i = 0; i < D + 2; i++) begin
      do_cycle(1, i % N, i, 0, 0, 0, 0, 64'(1000 + 20 * i));
      do_cycle(0, 0, 0, 1, i % N, i, 0, 64'(1005 + 20 * i + i));
    end
    chk("ovf_drops", 64'(res_drops), 2);
    cnt = 0;
    for (int i = 0; i < D + 3; i++) begin
      if (res_valid) cnt++;
      do_cycle(0, 0, 0, 0, 0, 0, 1, 2000);
    end
    chk("ovf_held", 64'(cnt), D);

    // Overrun then match, then clear
    do_clear();
    do_cycle(1, 0, 1, 0, 0, 0, 0, 3000);
    do_cycle(1, 0, 2, 0, 0, 0, 0, 3010);
    do_cycle(0, 0, 0, 1, 0, 2, 0, 3050);
    chk("ovr_lat", res_latency, 40);
    stat_chk("ovr_st0", 0, 1, 1, 40, 40);
    do_clear();
    chk("clr_valid", 64'(res_valid), 0);
    chk("clr_drops", 64'(res_drops), 0);
    stat_chk("clr_st0", 0, 0, 0, ONES, 0);

    // Timeout: scanner timing is bounded, not cycle-exact, so the model sits out
    use_model = 0;
    timeout = 1000;
    do_cycle(1, 2, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2 * N; i++) idle(1000);
    chk("to_boundary", 64'(res_valid), 0);
    for (int i = 0; i < N && !res_valid; i++) idle(1001);
    chk("to_valid", 64'(res_valid), 1);
    chk("to_ch", 64'(res_channel), 2);
    chk("to_lost", 64'(res_lost), 1);
    chk("to_lat", res_latency, 0);
    stat_chk("to_st2", 2, 0, 1, ONES, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 1, 1002);
    chk("to_pop", 64'(res_valid), 0);
    timeout = 0;
    use_model = 1;
    do_clear();

    // Randomized traffic against the model
    now = 64'd5000;
    for (int i = 0; i < 1500; i++) begin
      txc = int'($urandom % N);
      rxc = int'($urandom % N);
      rxs = ($urandom % 3 == 0) ? int'($urandom % 4) : m_seq[rxc];
      now += 64'($urandom_range(1, 40));
      do_cycle($urandom % 10 < 4, txc, int'($urandom % 4), $urandom % 2 == 0,
               rxc, rxs, $urandom % 2 == 0, now, $urandom % 8 != 0,
               $urandom % 300 == 0);
      if (i % 300 == 299)
        stat_chk("rnd_st", (i / 300) % N, m_ok[(i / 300) % N], m_lost[(i / 300) % N],
                 m_min[(i / 300) % N], m_max[(i / 300) % N]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
